pipe_reg_skid: RTL and testbench

Parametrised successor to the fixed 16-bit enable register. It is a single pipeline stage carrying WIDTH bits, with a valid/ready handshake on both sides and a one-entry skid buffer, so in_ready is driven from a register and never depends combinationally on out_ready. It has a synchronous flush for mispredict and exception squash. It sits between out-of-order pipeline stages such as dispatch to reservation station and issue to execute.

---
 rtl/ooo_pipe_pkg.sv | 12 +
 rtl/pipe_reg_bank.sv | 26 ++
 rtl/pipe_reg_skid.sv | 118 +++++++++++
 tb/tb_pipe_reg_skid.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ooo_pipe_pkg.sv
// Shared types and constants for the out-of-order pipeline register stages.
package ooo_pipe_pkg;

    localparam int PIPE_REG_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_reg_bank.sv
// WIDTH-wide register with load enable and synchronous clear; used for the
// main and skid slots of pipe_reg_skid.
module pipe_reg_bank #(
    parameter int WIDTH = ooo_pipe_pkg::PIPE_REG_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: reset is sampled on the clock edge and wins over clear and load;
    // sequential state is only ever assigned with <=.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Single valid/ready pipeline stage with a one-entry skid buffer and flush.
// Define PIPE_REG_SKID_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_reg_skid
    import ooo_pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_REG_DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
    end

    stage_state_t     state, state_nxt;
    logic             in_fire, out_fire;
    logic             main_en, main_from_skid, skid_en;
    logic [WIDTH-1:0] main_d, skid_q;

    // Valid bits are the state itself, so in_ready is a pure register decode.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (in_fire) state_nxt = BUSY;
                BUSY: begin
                    if (in_fire && !out_fire)      state_nxt = FULL;
                    else if (!in_fire && out_fire) state_nxt = EMPTY;
                end
                FULL:    if (out_fire) state_nxt = BUSY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        unique case (state)
            EMPTY: main_en = in_fire;
            BUSY: begin
                main_en = in_fire & out_fire;
                skid_en = in_fire & ~out_fire;
            end
            FULL: begin
                main_en        = out_fire;
                main_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_reg_bank #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    pipe_reg_bank #(.WIDTH(WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

`ifdef PIPE_REG_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Flush squashes data, not history: only reset clears the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Scoreboard bench for pipe_reg_skid: directed scenarios followed by random
// traffic, checked against a queue model of the stage contents.
module tb_pipe_reg_skid;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam int CAP   = 2;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] in_data, out_data;
`ifdef PIPE_REG_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    int               stall_m = 0;
`endif

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit               zero_exp = 1'b1;

    always #5 clk = ~clk;

    pipe_reg_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_REG_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the stage holds an ordered list of at most CAP accepted items.
    always @(negedge clk) begin
        int occ;
        occ = exp_q.size();
        check("in_ready", {31'd0, in_ready}, {31'd0, occ < CAP});
        check("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
        if (occ > 0)
            check("out_data", {16'd0, out_data}, {16'd0, exp_q[0]});
        else if (zero_exp)
            check("out_data_cleared", {16'd0, out_data}, 32'd0);
`ifdef PIPE_REG_SKID_STALL_CNT_EN
        check("stall_cnt", {28'd0, stall_cnt}, stall_m);
`endif
        if (!rst) begin
            exp_q.delete();
            zero_exp = 1'b1;
`ifdef PIPE_REG_SKID_STALL_CNT_EN
            stall_m = 0;
`endif
        end else begin
`ifdef PIPE_REG_SKID_STALL_CNT_EN
            if (occ > 0 && !out_ready && stall_m < (1 << CNT_W) - 1) stall_m++;
`endif
            if (occ > 0 && out_ready) void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
                zero_exp = 1'b1;
            end else if (in_valid && occ < CAP) begin
                exp_q.push_back(in_data);
                zero_exp = 1'b0;
            end
        end
    end

    task automatic cyc(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                       input logic fl, input logic rs);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset then stream 1..8 at full rate
        cyc(0, 16'h0, 0, 0, 0);
        cyc(0, 16'h0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 1, 0, 1);
        cyc(0, 16'h0, 1, 0, 1);
        cyc(0, 16'h0, 1, 0, 1);

        // Backpressure to FULL, then ignore while full, then drain
        cyc(1, 16'hAAAA, 0, 0, 1);
        cyc(1, 16'hBBBB, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 16'hCCCC, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 1, 0, 1);

        // Flush while full with a competing input
        cyc(1, 16'h1111, 0, 0, 1);
        cyc(1, 16'h2222, 0, 0, 1);
        cyc(1, 16'h3333, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(0, 16'h0, 1, 0, 1);

        // Reset has priority over flush and an input handshake
        cyc(1, 16'h4444, 0, 0, 1);
        cyc(1, 16'h5555, 1, 1, 0);
        cyc(0, 16'h0, 1, 0, 1);
        cyc(1, 16'h6666, 1, 0, 1);
        cyc(0, 16'h0, 1, 0, 1);

        // Long stall drives the counter to saturation; flush keeps it, reset clears it
        cyc(1, 16'h7777, 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc(0, 16'h0, 0, 0, 1);
        cyc(0, 16'h0, 0, 1, 1);
        cyc(0, 16'h0, 0, 0, 1);
        cyc(0, 16'h0, 0, 0, 0);
        cyc(0, 16'h0, 0, 0, 1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom),
                (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 4) == 0),
                $urandom_range(0, 59) == 0, $urandom_range(0, 249) != 0);
        end

        for (int i = 0; i < 4; i++) cyc(0, 16'h0, 1, 0, 1);
        @(negedge clk);
        #1;
        check("drained_out_valid", {31'd0, out_valid}, 32'd0);
        check("drained_scoreboard", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
